// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite-row ROM fetch arbiter.
package sprite_pkg;

   localparam int SPRITE_W = 3;
   localparam int ROW_W    = 5;
   localparam int DATA_W   = 32;

   // Sprite indices as stored in the sprite-row ROM
   localparam logic [SPRITE_W-1:0] TANK_UP    = 3'd0;
   localparam logic [SPRITE_W-1:0] TANK_LEFT  = 3'd1;
   localparam logic [SPRITE_W-1:0] TANK_DOWN  = 3'd2;
   localparam logic [SPRITE_W-1:0] TANK_RIGHT = 3'd3;
   localparam logic [SPRITE_W-1:0] BULLET     = 3'd4;
   localparam logic [SPRITE_W-1:0] BRICK      = 3'd5;
   localparam logic [SPRITE_W-1:0] BUSH       = 3'd6;
   localparam logic [SPRITE_W-1:0] ROCK       = 3'd7;

   typedef enum logic {
      ARB   = 1'b0,
      BURST = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/sprite_fetch_arbiter_rr_arbiter.sv
// Masked round-robin selector: picks the first eligible request after 'last'.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] mask,
   input  logic [ID_W-1:0]    last,
   output logic [NUM_REQ-1:0] onehot,
   output logic [ID_W-1:0]    idx,
   output logic               valid
);

   logic [NUM_REQ-1:0] eligible_s;
   logic               found_s;
   logic               take_s;

   // Walk last+1, last+2, ... and keep the first eligible requester found
   always_comb begin
      eligible_s = req & ~mask;
      onehot     = '0;
      idx        = '0;
      found_s    = 1'b0;
      take_s     = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int pos;
         pos     = (int'(last) + k) % NUM_REQ;
         take_s  = eligible_s[pos] & ~found_s;
         idx     = take_s ? ID_W'(pos) : idx;
         onehot  = take_s ? (NUM_REQ'(1) << pos) : onehot;
         found_s = found_s | eligible_s[pos];
      end
      valid = found_s;
   end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Round-robin arbiter sharing one combinational sprite-row ROM among several
// renderers, with single-row fetches and locked bursts to the sprite's last row.
module sprite_fetch_arbiter #(
   parameter  int NUM_REQ  = 4,
   parameter  int SPRITE_W = sprite_pkg::SPRITE_W,
   parameter  int ROW_W    = sprite_pkg::ROW_W,
   parameter  int DATA_W   = sprite_pkg::DATA_W,
   localparam int ID_W     = $clog2(NUM_REQ)
) (
   input  logic                         Clk,
   input  logic                         Reset_n,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ-1:0]           burst,
   input  logic [NUM_REQ*SPRITE_W-1:0]  sprite_id,
   input  logic [NUM_REQ*ROW_W-1:0]     row,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [SPRITE_W+ROW_W-1:0]    rom_addr,
   input  logic [DATA_W-1:0]            rom_data,
   output logic                         rd_valid,
   output logic [ID_W-1:0]              rd_id,
   output logic [DATA_W-1:0]            rd_data,
   output logic                         rd_last,
   output logic                         busy
);

   import sprite_pkg::*;

   localparam logic [ROW_W-1:0] LAST_ROW = {ROW_W{1'b1}};

   fetch_state_t          state_r;
   logic [ID_W-1:0]       last_r;
   logic [ID_W-1:0]       tag_id_r;
   logic                  tag_valid_r;
   logic                  tag_last_r;
   logic [SPRITE_W-1:0]   sprite_q_r;
   logic [ROW_W-1:0]      cnt_r;
   logic [ROW_W-1:0]      cnt_next_s;

   logic [NUM_REQ-1:0]    win_onehot_s;
   logic [ID_W-1:0]       win_idx_s;
   logic                  win_valid_s;
   logic [SPRITE_W-1:0]   win_sprite_s;
   logic [ROW_W-1:0]      win_row_s;
   logic                  win_burst_s;

   // The requester granted last cycle is masked so a held req is not granted twice
   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req    (req),
      .mask   (gnt),
      .last   (last_r),
      .onehot (win_onehot_s),
      .idx    (win_idx_s),
      .valid  (win_valid_s)
   );

   // Pick out the winner's sprite, start row and burst qualifier
   always_comb begin
      win_sprite_s = sprite_id[int'(win_idx_s)*SPRITE_W +: SPRITE_W];
      win_row_s    = row[int'(win_idx_s)*ROW_W +: ROW_W];
      win_burst_s  = burst[win_idx_s];
      cnt_next_s   = cnt_r + ROW_W'(1);
   end

   // Arbitration / burst FSM driving the registered ROM address and pipeline tag
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_r     <= ARB;
         last_r      <= ID_W'(NUM_REQ - 1);
         gnt         <= '0;
         rom_addr    <= '0;
         tag_id_r    <= '0;
         tag_valid_r <= 1'b0;
         tag_last_r  <= 1'b0;
         sprite_q_r  <= '0;
         cnt_r       <= '0;
         busy        <= 1'b0;
      end else begin
         case (state_r)
            ARB: begin
               if (win_valid_s) begin
                  gnt         <= win_onehot_s;
                  last_r      <= win_idx_s;
                  rom_addr    <= {win_sprite_s, win_row_s};
                  tag_id_r    <= win_idx_s;
                  tag_valid_r <= 1'b1;
                  if (win_burst_s && (win_row_s != LAST_ROW)) begin
                     sprite_q_r <= win_sprite_s;
                     cnt_r      <= win_row_s;
                     tag_last_r <= 1'b0;
                     busy       <= 1'b1;
                     state_r    <= BURST;
                  end else begin
                     // Single fetch, including a burst that starts on the last row
                     tag_last_r <= 1'b1;
                     busy       <= 1'b0;
                  end
               end else begin
                  gnt         <= '0;
                  tag_valid_r <= 1'b0;
                  tag_last_r  <= 1'b0;
                  busy        <= 1'b0;
               end
            end
            BURST: begin
               gnt         <= '0;
               cnt_r       <= cnt_next_s;
               rom_addr    <= {sprite_q_r, cnt_next_s};
               tag_valid_r <= 1'b1;
               if (cnt_next_s == LAST_ROW) begin
                  // Final row issued: the next cycle can arbitrate again
                  tag_last_r <= 1'b1;
                  busy       <= 1'b0;
                  state_r    <= ARB;
               end else begin
                  tag_last_r <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            default: begin
               gnt         <= '0;
               tag_valid_r <= 1'b0;
               tag_last_r  <= 1'b0;
               busy        <= 1'b0;
               state_r     <= ARB;
            end
         endcase
      end
   end

   // Return stage: capture the ROM row one cycle after its address was issued
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         rd_valid <= 1'b0;
         rd_id    <= '0;
         rd_data  <= '0;
         rd_last  <= 1'b0;
      end else begin
         rd_valid <= tag_valid_r;
         rd_id    <= tag_id_r;
         rd_data  <= rom_data;
         rd_last  <= tag_last_r;
      end
   end

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Self-checking bench for sprite_fetch_arbiter: ROM model, requester model and
// a scoreboard of expected return beats filled whenever a grant is observed.
module tb_sprite_fetch_arbiter;

   logic        Clk;
   logic        Reset_n;
   logic [3:0]  req;
   logic [3:0]  burst;
   logic [11:0] sprite_id;
   logic [19:0] row;
   logic [3:0]  gnt;
   logic [7:0]  rom_addr;
   logic [31:0] rom_data;
   logic        rd_valid;
   logic [1:0]  rd_id;
   logic [31:0] rd_data;
   logic        rd_last;
   logic        busy;

   logic [3:0]  hold;
   int          errors;
   int          checks;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] data;
      logic        last;
   } beat_t;

   typedef struct {
      int          idx;
      logic [2:0]  spr;
      logic [4:0]  rw;
      logic        bst;
      logic [3:0]  exp_gnt;
      logic [7:0]  exp_addr;
      logic [31:0] exp_data;
   } vec_t;

   beat_t sb[$];
   vec_t  vecs[5];

   sprite_fetch_arbiter dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .req       (req),
      .burst     (burst),
      .sprite_id (sprite_id),
      .row       (row),
      .gnt       (gnt),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .rd_valid  (rd_valid),
      .rd_id     (rd_id),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .busy      (busy)
   );

   // Sprite-row ROM contents: known rows fixed, everything else a unique pattern
   function automatic logic [31:0] tb_rom(input logic [2:0] sp, input logic [4:0] rw);
      logic [31:0] d;
      d = {sp, rw, 8'h5A, sp, rw, 8'hC3};
      if (sp == 3'd5 && rw == 5'd0) d = 32'hFF0FE0FF;
      if (sp == 3'd0 && rw == 5'd0) d = 32'h0003C000;
      if (sp == 3'd4) d = (rw >= 5'd14 && rw <= 5'd17) ? 32'h0003C000 : 32'h00000000;
      if (sp == 3'd7 && rw == 5'd31) d = 32'hE0000000;
      return d;
   endfunction

   assign rom_data = tb_rom(rom_addr[7:5], rom_addr[4:0]);

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_req(input int i, input int sp, input int rw, input logic b);
      req[i]             = 1'b1;
      burst[i]           = b;
      sprite_id[i*3 +: 3] = 3'(sp);
      row[i*5 +: 5]       = 5'(rw);
   endtask

   // One clock: on the falling edge score return beats, record grants, drop granted reqs
   task automatic step();
      beat_t      e;
      logic [2:0] sp;
      logic [4:0] r;
      @(negedge Clk);
      if (Reset_n) begin
         if (rd_valid) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_beat", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("sb_id", 64'(rd_id), 64'(e.id));
               chk("sb_data", 64'(rd_data), 64'(e.data));
               chk("sb_last", 64'(rd_last), 64'(e.last));
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (gnt[i]) begin
               sp = sprite_id[i*3 +: 3];
               r  = row[i*5 +: 5];
               if (burst[i] && r != 5'd31) begin
                  for (int rr = int'(r); rr <= 31; rr++)
                     sb.push_back('{id: 2'(i), data: tb_rom(sp, 5'(rr)), last: (rr == 31)});
               end else begin
                  sb.push_back('{id: 2'(i), data: tb_rom(sp, r), last: 1'b1});
               end
               if (!hold[i]) req[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      req     = 4'b0000;
      burst   = 4'b0000;
      hold    = 4'b0000;
      sb.delete();
      step();
      step();
      Reset_n = 1'b1;
   endtask

   initial begin
      int beats;
      int busy_cnt;
      Clk       = 1'b0;
      errors    = 0;
      checks    = 0;
      sprite_id = 12'h000;
      row       = 20'h00000;

      vecs[0] = '{idx: 1, spr: 3'd5, rw: 5'd0,  bst: 1'b0, exp_gnt: 4'b0010, exp_addr: 8'hA0, exp_data: 32'hFF0FE0FF};
      vecs[1] = '{idx: 3, spr: 3'd7, rw: 5'd31, bst: 1'b1, exp_gnt: 4'b1000, exp_addr: 8'hFF, exp_data: 32'hE0000000};
      vecs[2] = '{idx: 0, spr: 3'd0, rw: 5'd0,  bst: 1'b0, exp_gnt: 4'b0001, exp_addr: 8'h00, exp_data: 32'h0003C000};
      vecs[3] = '{idx: 2, spr: 3'd4, rw: 5'd15, bst: 1'b0, exp_gnt: 4'b0100, exp_addr: 8'h8F, exp_data: 32'h0003C000};
      vecs[4] = '{idx: 1, spr: 3'd3, rw: 5'd9,  bst: 1'b0, exp_gnt: 4'b0010, exp_addr: 8'h69, exp_data: 32'h695A69C3};

      // Reset state
      do_reset();
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_rom_addr", 64'(rom_addr), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_rd_id", 64'(rd_id), 64'd0);
      chk("rst_rd_data", 64'(rd_data), 64'd0);
      chk("rst_rd_last", 64'(rd_last), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);

      // Single fetches from a table, including a burst request starting on row 31
      for (int v = 0; v < 5; v++) begin
         set_req(vecs[v].idx, int'(vecs[v].spr), int'(vecs[v].rw), vecs[v].bst);
         step();
         chk("vec_gnt", 64'(gnt), 64'(vecs[v].exp_gnt));
         chk("vec_rom_addr", 64'(rom_addr), 64'(vecs[v].exp_addr));
         chk("vec_busy_gnt", 64'(busy), 64'd0);
         step();
         chk("vec_rd_valid", 64'(rd_valid), 64'd1);
         chk("vec_rd_id", 64'(rd_id), 64'(vecs[v].idx));
         chk("vec_rd_data", 64'(rd_data), 64'(vecs[v].exp_data));
         chk("vec_rd_last", 64'(rd_last), 64'd1);
         chk("vec_busy_rd", 64'(busy), 64'd0);
      end
      step();
      chk("vec_idle_valid", 64'(rd_valid), 64'd0);

      // Fairness: all four held, expect grants 0,1,2,3,0 on consecutive cycles
      do_reset();
      hold = 4'b1111;
      for (int i = 0; i < 4; i++) set_req(i, 0, 0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rr_gnt", 64'(gnt), 64'(4'b0001 << (k % 4)));
         if (k > 0) begin
            chk("rr_rd_valid", 64'(rd_valid), 64'd1);
            chk("rr_rd_data", 64'(rd_data), 64'h0003C000);
         end
      end
      req  = 4'b0000;
      hold = 4'b0000;
      for (int k = 0; k < 3; k++) step();

      // Full 32-row burst of the bullet sprite; busy drops on the edge issuing row 31
      set_req(2, 4, 0, 1'b1);
      step();
      chk("burst_gnt", 64'(gnt), 64'b0100);
      beats    = 0;
      busy_cnt = busy ? 1 : 0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (busy) busy_cnt++;
         if (gnt != 4'b0000) chk("burst_no_gnt", 64'(gnt), 64'd0);
         if (rd_valid) begin
            chk("burst_rd_id", 64'(rd_id), 64'd2);
            chk("burst_rd_data", 64'(rd_data),
                (beats >= 14 && beats <= 17) ? 64'h0003C000 : 64'h0);
            chk("burst_rd_last", 64'(rd_last), 64'(beats == 31));
            beats++;
         end
      end
      chk("burst_beats", 64'(beats), 64'd32);
      chk("burst_busy_cycles", 64'(busy_cnt), 64'd31);

      // Contention: requester 0 arrives two cycles into a burst from row 28
      set_req(2, 6, 28, 1'b1);
      step();
      chk("cont_gnt2", 64'(gnt), 64'b0100);
      chk("cont_addr28", 64'(rom_addr), 64'hDC);
      step();
      chk("cont_valid0", 64'(rd_valid), 64'd1);
      set_req(0, 1, 3, 1'b0);
      step();
      chk("cont_gnt_held", 64'(gnt), 64'd0);
      chk("cont_valid1", 64'(rd_valid), 64'd1);
      step();
      chk("cont_gnt_held2", 64'(gnt), 64'd0);
      chk("cont_addr31", 64'(rom_addr), 64'hDF);
      chk("cont_valid2", 64'(rd_valid), 64'd1);
      step();
      chk("cont_gnt0", 64'(gnt), 64'b0001);
      chk("cont_valid3", 64'(rd_valid), 64'd1);
      chk("cont_last3", 64'(rd_last), 64'd1);
      step();
      chk("cont_valid4", 64'(rd_valid), 64'd1);
      chk("cont_id4", 64'(rd_id), 64'd0);
      step();
      step();

      // Reset at beat 10 of a burst, then requesters 3 and 0 together
      set_req(1, 4, 0, 1'b1);
      step();
      beats = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (rd_valid) beats++;
         if (beats == 11) break;
      end
      chk("rst_burst_reached", 64'(beats), 64'd11);
      Reset_n = 1'b0;
      req     = 4'b0000;
      sb.delete();
      step();
      chk("midrst_rd_valid", 64'(rd_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_gnt", 64'(gnt), 64'd0);
      Reset_n = 1'b1;
      set_req(3, 1, 2, 1'b0);
      set_req(0, 3, 4, 1'b0);
      step();
      chk("post_rst_gnt0", 64'(gnt), 64'b0001);
      step();
      chk("post_rst_gnt3", 64'(gnt), 64'b1000);
      for (int k = 0; k < 4; k++) step();

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
